// File: rtl/cnn_fifo_pkg.sv
// Shared types and helpers for the CNN line FIFO and its pointer sub-module.
// LANE_W is the lane width also used by the MAC-BN stage.
package cnn_fifo_pkg;

    localparam int LANE_W = 16;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointer width for a given depth, never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Circular FIFO pointer: advances on en, wraps from DEPTH-1 to 0, and
// returns to 0 on clr or synchronous reset.
module fifo_wrap_ptr
    import cnn_fifo_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ptr_w(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] ptr
);

    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching the hardware.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/cnn_line_fifo.sv
// Multi-channel line FIFO with valid/ready handshake, FWFT or registered-read
// mode, flush, almost-full/empty thresholds, level and sticky error flags.
module cnn_line_fifo
    import cnn_fifo_pkg::*;
#(
    parameter int DEPTH      = 188,
    parameter int DATA_WIDTH = LANE_W,
    parameter int NUM_CH     = 4,
    parameter int FWFT       = 1,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic                           ovf_err,
    output logic                           udf_err,
    input  logic                           err_clr
);

    localparam int         PW   = ptr_w(DEPTH);
    localparam int         LW   = $clog2(DEPTH + 1);
    localparam int         EW   = NUM_CH * DATA_WIDTH;
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          full;
    logic          empty;
    logic          wr;
    logic          rd;
    logic          ovf_ev;
    logic          udf_ev;

    // Status is derived from the registered level only, so no ready/valid
    // output ever depends combinationally on the opposite side's request.
    assign full         = (level_q == DEPTH_L);
    assign empty        = (level_q == '0);
    assign in_ready     = !full;
    assign level        = level_q;
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);

    // Flush and reset suppress both transfers; a full FIFO refuses writes
    // even when a read happens in the same cycle.
    assign wr = rst_n && !flush && in_valid && !full;
    assign rd = rst_n && !flush && out_ready && !empty;

    assign ovf_ev = in_valid && full;
    assign udf_ev = (MODE == FIFO_STD) && out_ready && empty;

    fifo_wrap_ptr #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (wr),
        .ptr   (wr_ptr)
    );

    fifo_wrap_ptr #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (rd),
        .ptr   (rd_ptr)
    );

    // NOTE: the storage array has no reset; level gates every read, so stale
    // contents are never observed and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            level_q <= '0;
        end else if (wr && !rd) begin
            level_q <= level_q + LW'(1);
        end else if (rd && !wr) begin
            level_q <= level_q - LW'(1);
        end
    end

    // A fresh error event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            ovf_err <= ovf_ev || (ovf_err && !err_clr);
            udf_err <= udf_ev || (udf_err && !err_clr);
        end
    end

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            assign out_valid = !empty;
            assign out_data  = mem[rd_ptr];
        end else begin : g_std
            logic [EW-1:0] data_q;
            logic          valid_q;

            // rd already excludes flush, so a flush also drops the valid pulse.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd;
                    if (rd) begin
                        data_q <= mem[rd_ptr];
                    end
                end
            end

            assign out_valid = valid_q;
            assign out_data  = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_cnn_line_fifo.sv
// Self-checking bench for cnn_line_fifo: FWFT depth 188, registered-read
// depth 8, and a depth-5 instance driven from a table of vectors.
module tb_cnn_line_fifo;

    logic clk;

    // Instance A: defaults (DEPTH 188, FWFT)
    logic        a_rst_n, a_flush, a_in_valid, a_in_ready, a_out_ready, a_out_valid;
    logic        a_af, a_ae, a_ovf, a_udf, a_err_clr;
    logic [63:0] a_in_data, a_out_data;
    logic [7:0]  a_level;

    // Instance B: registered-read mode, DEPTH 8
    logic        b_rst_n, b_flush, b_in_valid, b_in_ready, b_out_ready, b_out_valid;
    logic        b_af, b_ae, b_ovf, b_udf, b_err_clr;
    logic [63:0] b_in_data, b_out_data;
    logic [3:0]  b_level;

    // Instance C: DEPTH 5, AF 4, AE 1, FWFT
    logic        c_rst_n, c_flush, c_in_valid, c_in_ready, c_out_ready, c_out_valid;
    logic        c_af, c_ae, c_ovf, c_udf, c_err_clr;
    logic [63:0] c_in_data, c_out_data;
    logic [2:0]  c_level;

    int          n_checks;
    int          n_fails;
    logic [63:0] a_q[$];
    logic [63:0] c_q[$];

    typedef struct {
        logic rst_n;
        logic in_valid;
        logic out_ready;
        int   lvl;
        logic af;
        logic ae;
        logic ir;
        logic ov;
        logic ovf;
    } vec_t;

    vec_t vec[19];

    cnn_line_fifo #(.DEPTH(188), .FWFT(1)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .flush(a_flush), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_data(a_in_data), .out_ready(a_out_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .level(a_level),
        .almost_full(a_af), .almost_empty(a_ae), .ovf_err(a_ovf),
        .udf_err(a_udf), .err_clr(a_err_clr)
    );

    cnn_line_fifo #(.DEPTH(8), .FWFT(0)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .flush(b_flush), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_data(b_in_data), .out_ready(b_out_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .level(b_level),
        .almost_full(b_af), .almost_empty(b_ae), .ovf_err(b_ovf),
        .udf_err(b_udf), .err_clr(b_err_clr)
    );

    cnn_line_fifo #(.DEPTH(5), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) dut_c (
        .clk(clk), .rst_n(c_rst_n), .flush(c_flush), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .in_data(c_in_data), .out_ready(c_out_ready),
        .out_valid(c_out_valid), .out_data(c_out_data), .level(c_level),
        .almost_full(c_af), .almost_empty(c_ae), .ovf_err(c_ovf),
        .udf_err(c_udf), .err_clr(c_err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard bookkeeping for instance A from pre-edge handshake state.
    task automatic step_a();
        if (!a_rst_n || a_flush) begin
            a_q.delete();
        end else begin
            if (a_in_valid && a_in_ready) a_q.push_back(a_in_data);
            if (a_out_valid && a_out_ready) begin
                if (a_q.size() == 0) check("a_unexpected_pop", 64'(a_out_valid), 64'd0);
                else check("a_data", a_out_data, a_q.pop_front());
            end
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        {a_flush, a_in_valid, a_out_ready, a_err_clr} = '0;
        {b_flush, b_in_valid, b_out_ready, b_err_clr} = '0;
        {c_flush, c_in_valid, c_out_ready, c_err_clr} = '0;
        a_in_data = '0; b_in_data = '0; c_in_data = '0;
        a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;

        //            rst  iv   ordy lvl af   ae   ir   ov   ovf
        vec[0]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[1]  = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[4]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[5]  = '{1'b1, 1'b1, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[6]  = '{1'b1, 1'b1, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[7]  = '{1'b1, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vec[8]  = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vec[9]  = '{1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vec[10] = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vec[11] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vec[12] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vec[13] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vec[14] = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vec[15] = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vec[16] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[17] = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vec[18] = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        tick();
        tick();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // ---------------- A: reset state ----------------
        check("a_rst_level", 64'(a_level), 64'd0);
        check("a_rst_in_ready", 64'(a_in_ready), 64'd1);
        check("a_rst_out_valid", 64'(a_out_valid), 64'd0);
        check("a_rst_af", 64'(a_af), 64'd0);
        check("a_rst_ae", 64'(a_ae), 64'd1);
        check("a_rst_ovf", 64'(a_ovf), 64'd0);
        check("a_rst_udf", 64'(a_udf), 64'd0);

        // ---------------- A: fill to full ----------------
        for (int i = 0; i < 188; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = {16'(i), 16'(i + 1), 16'(i + 2), 16'(i + 3)};
            step_a();
            if (i == 0) check("a_first_out_valid", 64'(a_out_valid), 64'd1);
            check("a_fill_level", 64'(a_level), 64'(i + 1));
            check("a_fill_af", 64'(a_af), 64'((i + 1) >= 184));
        end
        check("a_full_in_ready", 64'(a_in_ready), 64'd0);
        a_in_data = 64'hDEAD_BEEF_DEAD_BEEF;
        step_a();
        check("a_ovf_set", 64'(a_ovf), 64'd1);
        check("a_ovf_level", 64'(a_level), 64'd188);
        a_err_clr = 1'b1;
        step_a();
        check("a_ovf_beats_clr", 64'(a_ovf), 64'd1);
        a_err_clr  = 1'b0;
        a_in_valid = 1'b0;

        // ---------------- A: drain in order ----------------
        a_out_ready = 1'b1;
        for (int k = 1; k <= 188; k++) begin
            step_a();
            check("a_drain_level", 64'(a_level), 64'(188 - k));
            check("a_drain_ae", 64'(a_ae), 64'((188 - k) <= 4));
        end
        check("a_drained_out_valid", 64'(a_out_valid), 64'd0);
        step_a();
        check("a_fwft_empty_read_no_udf", 64'(a_udf), 64'd0);

        // ---------------- A: steady state with wrap ----------------
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a_in_data = {$urandom(), $urandom()};
            step_a();
        end
        a_out_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            a_in_data = {$urandom(), $urandom()};
            step_a();
            check("a_steady_level", 64'(a_level), 64'd100);
        end
        a_in_valid = 1'b0;
        for (int i = 0; i < 100; i++) step_a();
        check("a_sb_leftover", 64'(a_q.size()), 64'd0);
        check("a_wrap_end_level", 64'(a_level), 64'd0);

        // ---------------- A: flush overrides read and write ----------------
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            a_in_data = 64'(i);
            step_a();
        end
        check("a_pre_flush_level", 64'(a_level), 64'd50);
        a_out_ready = 1'b1;
        a_flush     = 1'b1;
        step_a();
        check("a_flush_level", 64'(a_level), 64'd0);
        check("a_flush_out_valid", 64'(a_out_valid), 64'd0);
        check("a_flush_keeps_ovf", 64'(a_ovf), 64'd1);
        check("a_flush_udf", 64'(a_udf), 64'd0);
        {a_flush, a_in_valid, a_out_ready} = '0;
        a_err_clr = 1'b1;
        step_a();
        a_err_clr = 1'b0;
        check("a_err_clr_ovf", 64'(a_ovf), 64'd0);

        // ---------------- B: registered-read mode ----------------
        check("b_rst_out_data", b_out_data, 64'd0);
        check("b_rst_out_valid", 64'(b_out_valid), 64'd0);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check("b_udf_set", 64'(b_udf), 64'd1);
        check("b_udf_out_valid", 64'(b_out_valid), 64'd0);
        check("b_udf_out_data", b_out_data, 64'd0);
        b_in_valid = 1'b1;
        b_in_data  = 64'hA5A5_A5A5_A5A5_A5A5;
        tick();
        b_in_valid = 1'b0;
        check("b_write_level", 64'(b_level), 64'd1);
        check("b_no_read_valid", 64'(b_out_valid), 64'd0);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check("b_read_valid", 64'(b_out_valid), 64'd1);
        check("b_read_data", b_out_data, 64'hA5A5_A5A5_A5A5_A5A5);
        check("b_read_level", 64'(b_level), 64'd0);
        tick();
        check("b_valid_pulse", 64'(b_out_valid), 64'd0);
        check("b_data_hold", b_out_data, 64'hA5A5_A5A5_A5A5_A5A5);
        b_in_valid = 1'b1;
        b_in_data  = 64'h11;
        tick();
        b_in_data  = 64'h22;
        tick();
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        tick();
        check("b_order0_valid", 64'(b_out_valid), 64'd1);
        check("b_order0_data", b_out_data, 64'h11);
        tick();
        check("b_order1_valid", 64'(b_out_valid), 64'd1);
        check("b_order1_data", b_out_data, 64'h22);
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 64'h33;
        tick();
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        b_flush     = 1'b1;
        tick();
        {b_out_ready, b_flush} = '0;
        check("b_flush_valid", 64'(b_out_valid), 64'd0);
        check("b_flush_level", 64'(b_level), 64'd0);
        check("b_flush_keeps_udf", 64'(b_udf), 64'd1);
        b_err_clr = 1'b1;
        tick();
        b_err_clr = 1'b0;
        check("b_err_clr_udf", 64'(b_udf), 64'd0);

        // ---------------- C: table of threshold / reset vectors ----------------
        for (int k = 0; k < 19; k++) begin
            c_rst_n     = vec[k].rst_n;
            c_in_valid  = vec[k].in_valid;
            c_out_ready = vec[k].out_ready;
            c_in_data   = 64'h100 + 64'(k);
            if (!c_rst_n) begin
                c_q.delete();
            end else begin
                if (c_in_valid && c_in_ready) c_q.push_back(c_in_data);
                if (c_out_valid && c_out_ready) begin
                    if (c_q.size() == 0) check("c_unexpected_pop", 64'(c_out_valid), 64'd0);
                    else check($sformatf("c_row%0d_data", k), c_out_data, c_q.pop_front());
                end
            end
            tick();
            check($sformatf("c_row%0d_level", k), 64'(c_level), 64'(vec[k].lvl));
            check($sformatf("c_row%0d_af", k), 64'(c_af), 64'(vec[k].af));
            check($sformatf("c_row%0d_ae", k), 64'(c_ae), 64'(vec[k].ae));
            check($sformatf("c_row%0d_in_ready", k), 64'(c_in_ready), 64'(vec[k].ir));
            check($sformatf("c_row%0d_out_valid", k), 64'(c_out_valid), 64'(vec[k].ov));
            check($sformatf("c_row%0d_ovf", k), 64'(c_ovf), 64'(vec[k].ovf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
